// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and constants
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 868;
    localparam int BAUD_CNT_W           = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter with clear and end-of-bit tick
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  clr,
    output logic [BAUD_CNT_W-1:0] cnt,
    output logic                  bit_tick
);

    localparam logic [BAUD_CNT_W-1:0] LAST = BAUD_CNT_W'(CLKS_PER_BIT - 1);

    logic [BAUD_CNT_W-1:0] cnt_q;
    logic [BAUD_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d    = cnt_q;
        bit_tick = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d    = '0;
            bit_tick = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/uart_fifo_tx.sv
// rtl/uart_fifo_tx.sv - 8N1 UART transmitter draining a standard-read byte FIFO
module uart_fifo_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       srst,
    input  logic [7:0] fifo_dout,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam logic [BAUD_CNT_W-1:0] DONE_AT  = BAUD_CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [2:0]            LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_t           state_q, state_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  tx_done_q, tx_done_d;
    logic                  fifo_rd_en_q, fifo_rd_en_d;
    logic                  cnt_clr;
    logic                  bit_tick;
    logic [BAUD_CNT_W-1:0] cnt;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .srst     (srst),
        .clr      (cnt_clr),
        .cnt      (cnt),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        cnt_clr   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!fifo_empty) state_d = FETCH;
            end
            FETCH: begin
                cnt_clr = 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                cnt_clr   = 1'b1;
                shift_d   = fifo_dout;
                bit_idx_d = '0;
                state_d   = START;
            end
            START: begin
                if (bit_tick) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_BIT) state_d = STOP;
                end
            end
            STOP: begin
                if (bit_tick) state_d = fifo_empty ? IDLE : FETCH;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next-cycle view so tx never sees a comb path.
        tx_d         = (state_d == START) ? 1'b0 :
                       (state_d == DATA)  ? shift_d[0] : 1'b1;
        busy_d       = (state_d != IDLE);
        fifo_rd_en_d = (state_d == FETCH);
        tx_done_d    = (state_q == STOP) && (cnt == DONE_AT) && !cnt_clr;
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            tx_done_q    <= 1'b0;
            fifo_rd_en_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            tx_done_q    <= tx_done_d;
            fifo_rd_en_q <= fifo_rd_en_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign tx_done    = tx_done_q;
    assign fifo_rd_en = fifo_rd_en_q;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb/tb_uart_fifo_tx.sv - self-checking bench for uart_fifo_tx with a FIFO model
module tb_uart_fifo_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk        = 1'b0;
    logic       srst       = 1'b1;
    logic [7:0] fifo_dout  = 8'h00;
    logic       fifo_empty = 1'b1;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       tx_done;

    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;

    logic [7:0] fq[$];
    logic [7:0] model_bytes[$];
    logic [3:0] exp_q[$];
    logic       tx_hist [0:8191];
    logic [7:0] rx_bytes[$];
    int         rx_starts[$];
    logic [9:0] rx_raw[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   n_rd = 0;
    int   n_done = 0;
    int   n_busy_drop = 0;
    int   last_rd_cyc = 0;
    int   last_wr_cyc = 0;
    logic prev_busy = 1'b0;

    logic [7:0] burst [0:15] = '{8'h00, 8'hFF, 8'h5A, 8'h81, 8'h3E, 8'hC7, 8'h12, 8'hE9,
                                 8'h6D, 8'hB4, 8'h07, 8'h98, 8'h2F, 8'hF0, 8'h41, 8'hAC};

    uart_fifo_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .srst       (srst),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Standard-read FIFO: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
        if (wr_en) fq.push_back(wr_data);
        fifo_empty <= (fq.size() == 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: actual none required event (cycle %0d)", name, cyc);
    endtask

    // One frame as seen on the pins: read strobe, load cycle, then 10 bits of CPB cycles.
    // Each entry is {tx, busy, rd_en, tx_done}.
    task automatic schedule(input logic [7:0] b);
        logic v;
        exp_q.push_back(4'b1110);
        exp_q.push_back(4'b1100);
        for (int k = 0; k < 10; k++) begin
            v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            for (int j = 0; j < CPB; j++)
                exp_q.push_back({v, 1'b1, 1'b0, (k == 9 && j == CPB - 1)});
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] e;
        e = 4'b1000;
        if (cyc < 8192) tx_hist[cyc] = tx;
        if (srst) exp_q.delete();
        else if (exp_q.size() > 0) e = exp_q.pop_front();
        check("tx", tx, e[3]);
        check("busy", busy, e[2]);
        check("rd_en", fifo_rd_en, e[1]);
        check("tx_done", tx_done, e[0]);
        if (fifo_rd_en) begin
            n_rd++;
            last_rd_cyc = cyc;
            check("rd_while_empty", fifo_empty, 1'b0);
        end
        if (tx_done) n_done++;
        if (prev_busy && !busy) n_busy_drop++;
        prev_busy = busy;
        if (!srst && exp_q.size() == 0 && !fifo_empty) begin
            if (model_bytes.size() == 0) fail("model_byte_available");
            else schedule(model_bytes.pop_front());
        end
    end

    task automatic push_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        last_wr_cyc = cyc;
        model_bytes.push_back(b);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int quiet = 0;
        for (int k = 0; k < budget && quiet < 4; k++) begin
            @(negedge clk);
            if (!busy && fifo_empty && !wr_en) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) fail("wait_idle_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fall(input int budget, output int f);
        f = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (tx == 1'b0) begin
                f = cyc;
                break;
            end
        end
        if (f < 0) fail("wait_fall_timeout");
    endtask

    // Recover frames from the recorded line by sampling mid-bit after each falling edge.
    task automatic decode(input int lo, input int hi);
        int i = lo + 1;
        rx_bytes.delete();
        rx_starts.delete();
        rx_raw.delete();
        while (i + FRAME <= hi) begin
            if (tx_hist[i-1] == 1'b1 && tx_hist[i] == 1'b0) begin
                logic [9:0] s;
                for (int k = 0; k < 10; k++) s[k] = tx_hist[i + CPB * k + CPB / 2];
                rx_raw.push_back(s);
                rx_bytes.push_back(s[8:1]);
                rx_starts.push_back(i);
                i += FRAME;
            end else begin
                i++;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual running required finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        int t0, rd0, d0, bd0, f;
        srst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        srst = 1'b0;

        repeat (50) @(posedge clk);
        #1;
        check("reset_idle_rd_count", n_rd, 0);
        check("reset_idle_tx", tx, 1'b1);
        check("reset_idle_busy", busy, 1'b0);

        t0 = cyc; rd0 = n_rd; d0 = n_done;
        push_byte(8'hA5);
        wait_idle(200);
        decode(t0, cyc);
        check("a5_frames", rx_bytes.size(), 1);
        if (rx_bytes.size() > 0) begin
            check("a5_byte", rx_bytes[0], 8'hA5);
            check("a5_line", rx_raw[0], 10'b1101001010);
            check("a5_latency_rd", last_rd_cyc - last_wr_cyc, 2);
            check("a5_latency_tx", rx_starts[0] - last_rd_cyc, 2);
        end
        check("a5_rd_pulses", n_rd - rd0, 1);
        check("a5_tx_done", n_done - d0, 1);
        check("a5_fifo_empty", fifo_empty, 1'b1);

        t0 = cyc; rd0 = n_rd;
        for (int k = 0; k < 16; k++) push_byte(burst[k]);
        wait_idle(16 * (FRAME + 10) + 100);
        decode(t0, cyc);
        check("burst_frames", rx_bytes.size(), 16);
        for (int k = 0; k < 16 && k < rx_bytes.size(); k++)
            check("burst_byte", rx_bytes[k], burst[k]);
        for (int k = 1; k < rx_starts.size(); k++)
            check("burst_start_gap", rx_starts[k] - rx_starts[k-1], FRAME + 2);
        check("burst_rd_pulses", n_rd - rd0, 16);

        push_byte(8'h3C);
        push_byte(8'h7E);
        wait_fall(100, f);
        repeat (15) @(posedge clk);
        #1;
        srst = 1'b1;
        #1;
        check("abort_tx_high", tx, 1'b1);
        check("abort_busy_low", busy, 1'b0);
        @(posedge clk);
        #1;
        srst = 1'b0;
        t0 = cyc; rd0 = n_rd;
        wait_idle(200);
        decode(t0, cyc);
        check("abort_frames", rx_bytes.size(), 1);
        if (rx_bytes.size() > 0) check("abort_next_byte", rx_bytes[0], 8'h7E);
        check("abort_rd_pulses", n_rd - rd0, 1);

        t0 = cyc; rd0 = n_rd; bd0 = n_busy_drop;
        push_byte(8'hFF);
        wait_fall(100, f);
        repeat (37) @(posedge clk);
        #1;
        push_byte(8'h55);
        wait_idle(200);
        decode(t0, cyc);
        check("stop_fetch_frames", rx_bytes.size(), 2);
        if (rx_bytes.size() == 2) begin
            check("stop_fetch_first", rx_bytes[0], 8'hFF);
            check("stop_fetch_second", rx_bytes[1], 8'h55);
            check("stop_fetch_gap", rx_starts[1] - rx_starts[0], FRAME + 2);
        end
        check("stop_fetch_busy_drops", n_busy_drop - bd0, 1);
        check("stop_fetch_rd_pulses", n_rd - rd0, 2);

        check("fifo_drained", fq.size(), 0);
        check("model_drained", model_bytes.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_fifo_tx.md
UART_FIFO_TX -- requirements
Module: uart_fifo_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 clk  input  1  single system clock, all logic on rising edge.
REQ-003 srst  input  1  reset, asynchronous, active-high.
REQ-004 fifo_dout  input  8  read data from the byte FIFO, valid the cycle after a fifo_rd_en cycle (standard, non-FWFT read).
REQ-005 fifo_empty  input  1  FIFO has no data.
REQ-006 fifo_rd_en  output  1  FIFO read strobe, registered, one-cycle pulse per byte.
REQ-007 tx  output  1  serial line, idle high, 8N1, LSB first.
REQ-008 busy  output  1  high from FETCH through the final STOP cycle.
REQ-009 tx_done  output  1  one-cycle pulse on the last clk of each stop bit.

Function
REQ-010 FSM states SHALL be IDLE, FETCH, LOAD, START, DATA, STOP.
REQ-011 IDLE: tx=1, busy=0; if fifo_empty=0 -> FETCH next cycle, else stay.
REQ-012 FETCH: fifo_rd_en=1 for exactly this cycle -> LOAD.
REQ-013 LOAD: shift register captures fifo_dout at end of cycle; baud counter cleared -> START.
REQ-014 Latency: fifo_empty sampled low in IDLE at cycle N -> fifo_rd_en high N+1 -> tx falls at N+3.
REQ-015 START: tx=0 for CLKS_PER_BIT cycles -> DATA, bit index 0.
REQ-016 DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shift right each bit, index 0..7; after bit 7 -> STOP.
REQ-017 STOP: tx=1 for CLKS_PER_BIT cycles; on last cycle tx_done=1 and next state FETCH if fifo_empty=0, else IDLE.
REQ-018 Back-to-back frames SHALL have tx high for exactly CLKS_PER_BIT+2 cycles between successive start bits' preceding data (stop bit plus FETCH, LOAD).
REQ-019 Baud counter width SHALL be 16 bits, counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary; bit index 3 bits.
REQ-020 fifo_rd_en SHALL never assert while fifo_empty=1 was sampled in the deciding cycle (no underflow reads).
REQ-021 fifo_empty changes while START/DATA/STOP SHALL not affect the frame in progress.
REQ-022 tx SHALL be glitch-free: driven from a register, no combinational path from inputs.

Reset
REQ-023 srst=1 SHALL immediately force state IDLE, tx=1, busy=0, tx_done=0, fifo_rd_en=0, counters and shift register 0.
REQ-024 srst asserted mid-frame SHALL abort the frame (tx high at once); the aborted byte is lost, not re-read.
REQ-025 After srst deasserts, first possible fifo_rd_en is the second rising edge (IDLE sampling per REQ-011).

Structure
REQ-026 Shared package uart_pkg SHALL hold the state enumeration, DATA_BITS=8 and default CLKS_PER_BIT constant.
REQ-027 Sub-module uart_baud_cnt (counter with clear and bit-tick output) is natural and SHALL be reusable by the receiver.
REQ-028 The block SHALL connect directly to fifo_generator_0 (dout, empty, rd_en); no internal buffering beyond the shift register.

Verification (CLKS_PER_BIT=4, fifo_generator_0 model attached)
REQ-029 Reset: srst pulse -> tx=1, busy=0, fifo_rd_en=0 while FIFO empty for 50 cycles.
REQ-030 Single byte 0xA5 written -> one fifo_rd_en pulse; tx = 0,1,0,1,0,0,1,0,1,1 each held 4 cycles (40 cycles); tx_done once; FIFO empty after.
REQ-031 Burst 16 random bytes written at one per cycle -> 16 frames, bytes received in order, 16 rd_en pulses, inter-frame gap per REQ-018, no read with empty=1.
REQ-032 srst asserted at cycle 15 of frame carrying 0x3C -> tx=1 same cycle, next FIFO byte 0x7E sent intact after release; 0x3C never reappears.
REQ-033 Write 0x55 during STOP of preceding 0xFF frame -> direct STOP->FETCH transition, busy stays high, 0x55 frame follows with 2-cycle gap.
